// File: rtl/ram_copy_engine.sv
// Block copy / block fill initiator that masters the data RAM's single synchronous port.
// Optional running write checksum output when RAM_COPY_CHECKSUM_EN is defined.
module ram_copy_engine #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic [DATA_WIDTH-1:0] fill_value,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_COPY_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   // state  | meaning
   // S_IDLE | waiting for start, RAM port unused
   // S_RD   | copy: present source address
   // S_WR   | copy: write returned read data to destination
   // S_FILL | fill: write latched constant to destination
   // S_FIN  | one-cycle done pulse, then back to idle
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_FILL = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   src_ptr;
   logic [ADDR_WIDTH-1:0]   dst_ptr;
   logic [ADDR_WIDTH:0]     cnt;
   logic [DATA_WIDTH-1:0]   fill_reg;
   logic                    load;
   logic                    adv_src;
   logic                    adv_dst;
   logic                    last_word;

   assign last_word = (cnt == CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      adv_src   = 1'b0;
      adv_dst   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load = 1'b1;
               if (length == '0) begin
                  state_nxt = S_FIN;
               end else if (mode) begin
                  state_nxt = S_FILL;
               end else begin
                  state_nxt = S_RD;
               end
            end
         end
         S_RD: begin
            state_nxt = S_WR;
         end
         S_WR: begin
            adv_src   = 1'b1;
            adv_dst   = 1'b1;
            state_nxt = last_word ? S_FIN : S_RD;
         end
         S_FILL: begin
            adv_dst   = 1'b1;
            state_nxt = last_word ? S_FIN : S_FILL;
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      // abort overrides sequencing only once an operation is underway
      if (state != S_IDLE && abort) begin
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ptr  <= '0;
         dst_ptr  <= '0;
         cnt      <= '0;
         fill_reg <= '0;
      end else if (load) begin
         src_ptr  <= src_addr;
         dst_ptr  <= dst_addr;
         cnt      <= length;
         fill_reg <= fill_value;
      end else begin
         if (adv_src) begin
            src_ptr <= src_ptr + ADDR_ONE;
         end
         if (adv_dst) begin
            dst_ptr <= dst_ptr + ADDR_ONE;
            cnt     <= cnt - CNT_ONE;
         end
      end
   end

   // RAM port is decoded from state and registers; only write data passes ram_rdata through
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_FIN);
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         S_RD: begin
            ram_addr = src_ptr;
         end
         S_WR: begin
            ram_we    = 1'b1;
            ram_addr  = dst_ptr;
            ram_wdata = ram_rdata;
         end
         S_FILL: begin
            ram_we    = 1'b1;
            ram_addr  = dst_ptr;
            ram_wdata = fill_reg;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

`ifdef RAM_COPY_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (load) begin
         checksum <= '0;
      end else if (ram_we) begin
         checksum <= checksum + ram_wdata;
      end
   end
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural synchronous RAM.
// Checksum checks are included when RAM_COPY_CHECKSUM_EN is defined.
module tb_ram_copy_engine;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [11:0] src_addr;
   logic [11:0] dst_addr;
   logic [12:0] length;
   logic [7:0]  fill_value;
   logic        abort;
   logic        busy;
   logic        done;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
`ifdef RAM_COPY_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   logic [7:0]  mem [0:4095];
   logic [11:0] wq_addr [$];
   int          wq_cyc [$];
   int          cyc;
   int          done_cnt;

   int          errors;
   int          checks;

   ram_copy_engine #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .fill_value (fill_value),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
`ifdef RAM_COPY_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wq_addr.push_back(ram_addr);
         wq_cyc.push_back(cyc);
      end
      if (done) done_cnt <= done_cnt + 1;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // starts an operation and returns edges from start until done is seen (-1 on timeout)
   task automatic run_op(input logic m, input logic [11:0] s, input logic [11:0] d,
                         input logic [12:0] len, input logic [7:0] fv,
                         input int budget, output int lat);
      mode       = m;
      src_addr   = s;
      dst_addr   = d;
      length     = len;
      fill_value = fv;
      start      = 1'b1;
      lat        = -1;
      for (int n = 1; n <= budget; n++) begin
         tick();
         start = 1'b0;
         abort = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      tick();
   endtask

   int lat;
   int wbase;
   int dbase;
   int found;

   initial begin
      errors = 0; checks = 0;
      cyc = 0; done_cnt = 0;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr_wdata", {12'd0, ram_addr, ram_wdata}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // whole-RAM fill with wrap
      wbase = wq_addr.size();
      run_op(1'b1, 12'h000, 12'h123, 13'd4096, 8'h3C, 5000, lat);
      chk("full_lat", lat, 32'd4097);
      chk("full_wcnt", wq_addr.size() - wbase, 32'd4096);
      chk("full_first", {20'd0, wq_addr[wbase]}, 32'h123);
      chk("full_last", {20'd0, wq_addr[wbase + 4095]}, 32'h122);
      chk("full_mem0", {24'd0, mem[0]}, 32'h3C);

      // basic copy
      mem[12'h010] <= 8'h11; mem[12'h011] <= 8'h22;
      mem[12'h012] <= 8'h33; mem[12'h013] <= 8'h44;
      tick();
      wbase = wq_addr.size();
      run_op(1'b0, 12'h010, 12'h200, 13'd4, 8'h00, 50, lat);
      chk("copy_lat", lat, 32'd9);
      chk("copy_wcnt", wq_addr.size() - wbase, 32'd4);
      chk("copy_data", {mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]}, 32'h11223344);
      chk("copy_busy_after", {31'd0, busy}, 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
      tick();
      chk("copy_csum", {24'd0, checksum}, 32'hAA);
`endif

      // fill across the top of the address space
      wbase = wq_addr.size();
      run_op(1'b1, 12'h000, 12'hFFE, 13'd4, 8'hA5, 50, lat);
      chk("fill_lat", lat, 32'd5);
      chk("fill_wcnt", wq_addr.size() - wbase, 32'd4);
      chk("fill_addrs", {wq_addr[wbase][7:0], wq_addr[wbase+1][7:0],
                         wq_addr[wbase+2][7:0], wq_addr[wbase+3][7:0]}, 32'hFEFF0001);
      chk("fill_addr_hi", {8'd0, wq_addr[wbase][11:8], wq_addr[wbase+1][11:8],
                           wq_addr[wbase+2][11:8], wq_addr[wbase+3][11:8]}, 32'h00FF00);
      chk("fill_consec", wq_cyc[wbase+3] - wq_cyc[wbase], 32'd3);
      chk("fill_data", {mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]}, 32'hA5A5A5A5);

`ifdef RAM_COPY_CHECKSUM_EN
      run_op(1'b1, 12'h000, 12'h700, 13'd3, 8'h80, 50, lat);
      chk("fill_csum", {24'd0, checksum}, 32'h80);
`endif

      // zero length
      wbase = wq_addr.size();
      run_op(1'b0, 12'h010, 12'h300, 13'd0, 8'h00, 20, lat);
      chk("zero_lat", lat, 32'd1);
      chk("zero_wcnt", wq_addr.size() - wbase, 32'd0);

      // start while busy is ignored
      wbase = wq_addr.size();
      dbase = done_cnt;
      mode = 1'b0; src_addr = 12'h010; dst_addr = 12'h300; length = 13'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      mode = 1'b1; length = 13'd0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("busy_start_done", done_cnt - dbase, 32'd1);
      chk("busy_start_wcnt", wq_addr.size() - wbase, 32'd2);
      chk("busy_start_data", {16'd0, mem[12'h300], mem[12'h301]}, 32'h1122);

      // abort after second write of a six-word copy
      for (int i = 0; i < 6; i++) mem[12'h020 + 12'(i)] <= 8'(i + 1);
      tick();
      wbase = wq_addr.size();
      dbase = done_cnt;
      mode = 1'b0; src_addr = 12'h020; dst_addr = 12'h400; length = 13'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int n = 0; n < 30; n++) begin
         if (wq_addr.size() - wbase >= 2) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("abort_reach2", found, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (10) tick();
      chk("abort_wcnt", wq_addr.size() - wbase, 32'd2);
      chk("abort_no_done", done_cnt - dbase, 32'd0);
      chk("abort_data", {8'd0, mem[12'h400], mem[12'h401], mem[12'h402]}, 32'h01023C);

      // start and abort together in idle: start wins
      abort = 1'b1;
      run_op(1'b1, 12'h000, 12'h500, 13'd1, 8'h5A, 20, lat);
      chk("start_abort_lat", lat, 32'd2);
      chk("start_abort_data", {24'd0, mem[12'h500]}, 32'h5A);

      // overlapping ascending copy propagates the first word
      mem[12'h100] <= 8'h07; mem[12'h101] <= 8'h00;
      mem[12'h102] <= 8'h00; mem[12'h103] <= 8'h00;
      tick();
      run_op(1'b0, 12'h100, 12'h101, 13'd3, 8'h00, 50, lat);
      chk("overlap_lat", lat, 32'd7);
      chk("overlap_data", {8'd0, mem[12'h101], mem[12'h102], mem[12'h103]}, 32'h070707);

      // asynchronous reset mid-fill
      mode = 1'b1; dst_addr = 12'h600; length = 13'd10; fill_value = 8'h99;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("midfill_active", {31'd0, ram_we}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", {9'd0, busy, done, ram_we, ram_addr, ram_wdata}, 32'd0);
      wbase = wq_addr.size();
      repeat (3) tick();
      chk("midrst_nowrite", wq_addr.size() - wbase, 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("midrst_idle", {30'd0, busy, ram_we}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Memory-port initiator that masters the data RAM's single synchronous port: drives address, write enable and write data, and consumes read data that arrives one cycle after the read address.
- Performs block copy (RAM to RAM) and block fill (constant to RAM) on request from the control unit.
- Sits between the control unit and the RAM; the control unit muxes RAM port ownership to this block while busy is high.

Parameters:
- ADDR_WIDTH, 12, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; latched on accepted start.
- src_addr  input  ADDR_WIDTH  copy source base; latched on start.
- dst_addr  input  ADDR_WIDTH  destination base; latched on start.
- length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; latched on start.
- fill_value  input  DATA_WIDTH  fill constant; latched on start.
- abort  input  1  terminate active operation.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on normal completion.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after its address is presented.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, ram_we = 0; ram_addr, ram_wdata = 0; all internal registers cleared. Reset mid-operation abandons the operation with no further writes.
- States: IDLE, RD, WR, FILL, FIN.
- IDLE: ram_we = 0. When start = 1:
  - length = 0 goes to FIN. No RAM access.
  - mode = 0 goes to RD.
  - mode = 1 goes to FILL.
  - Operands are latched and the remaining-word counter is loaded with length.
- RD (copy): ram_addr = src pointer, ram_we = 0. Next state WR.
- WR (copy): ram_addr = dst pointer, ram_we = 1, ram_wdata = ram_rdata. On the edge:
  - Both pointers increment.
  - The counter decrements.
  - Next state is FIN if the counter was 1, otherwise RD.
  - Throughput: 2 cycles per word.
- FILL: ram_addr = dst pointer, ram_we = 1, ram_wdata = fill_value (latched). On the edge, the dst pointer increments and the counter decrements. Next state is FIN if the counter was 1, otherwise stay in FILL. Throughput: 1 cycle per word.
- FIN: done = 1, busy = 1, ram_we = 0. Next state IDLE.
- busy = 1 in RD, WR, FILL and FIN; busy = 0 in IDLE.
- Latency from the accepting edge to done high:
  - copy: 2N+1 cycles
  - fill: N+1 cycles
  - length = 0: 1 cycle
- ram_* outputs decode from state and registers only; there is no combinational path from start, abort or operand inputs.
- Pointers wrap from 2^ADDR_WIDTH-1 to 0.
- length = 2^ADDR_WIDTH is legal and covers the whole RAM.
- Copy is always ascending. Overlapping ranges with dst > src propagate already-written data; this is the defined result, not an error.
- abort = 1 in any non-IDLE state: next state IDLE, done is not pulsed, and the current cycle's write (if ram_we = 1) still completes. abort in IDLE has no effect.
- start while busy is ignored.
- start and abort asserted together in IDLE: start is accepted and abort is ignored for that cycle.

Optional Feature:
- Macro: RAM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_WIDTH-1:0], cleared to 0 on reset and on each accepted start.
  - Adds ram_wdata modulo 2^DATA_WIDTH every cycle ram_we = 1.
  - Holds its value after done until the next start.
- Undefined: no checksum port or logic exists; all other behaviour is identical.

Test Plan:
- Copy with RAM preloaded 0x010..0x013 = 11,22,33,44, src 0x010, dst 0x200, length 4 -> done 9 cycles after start; 0x200..0x203 = 11,22,33,44; exactly 4 ram_we pulses.
- Fill 0xA5, dst 0xFFE, length 4 -> writes 0xFFE, 0xFFF, 0x000, 0x001 on consecutive cycles; done 5 cycles after start.
- length 0 -> done 1 cycle after start, no ram_we; start pulsed during busy -> ignored, with no second done.
- abort asserted after the 2nd write of a 6-word copy -> exactly 2 words written, busy low next cycle, no done; rst_n low mid-fill -> all outputs 0 immediately.
- Overlap copy src 0x100, dst 0x101, length 3, with 0x100 = 7 -> 0x101..0x103 = 7,7,7.
- With RAM_COPY_CHECKSUM_EN: fill 0x80, length 3 -> checksum = 0x80; copy 11,22,33,44 -> checksum = 0xAA.
